// File: rtl/rom_seq_pkg.sv
// Shared types and board defaults for the ROM address sequencer and its button debouncer.
package rom_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ISSUE   = 2'b01,
    ST_WAIT    = 2'b10,
    ST_CAPTURE = 2'b11
  } seq_state_t;

  localparam int unsigned CLK_HZ               = 50_000_000;
  localparam int unsigned DEBOUNCE_CYCLES_DFLT = CLK_HZ / 50;  // 20 ms
  localparam int unsigned SCAN_DIV_DFLT        = CLK_HZ / 2;   // 2 Hz

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Active-low button to single-cycle press pulse: 2-FF sync, stable-count filter, falling-edge detect.
// Latency 2 sync + DEBOUNCE_CYCLES clocks from a stable level change to the press pulse; no backpressure.
module btn_debounce
  import rom_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          level_n_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1   <= 1'b1;
      sync_q2   <= 1'b1;
      level_n_q <= 1'b1;
      cnt_q     <= '0;
      press     <= 1'b0;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
      press   <= 1'b0;
      // Any sample that agrees with the accepted level restarts the stability run.
      if (sync_q2 == level_n_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q     <= '0;
        level_n_q <= sync_q2;
        press     <= level_n_q & ~sync_q2;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rom_addr_sequencer.sv
// Steps the ROM address on a debounced press or auto-scan tick; request to data_valid is ROM_LATENCY+2.
// No flow control: one request arriving while busy is held in a pending flag, further ones are dropped.
module rom_addr_sequencer
  import rom_seq_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned ROM_LATENCY     = 1,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter int unsigned SCAN_DIV        = SCAN_DIV_DFLT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     btn_step_n,
  input  logic                     mode_auto,
  input  logic                     load_en,
  input  logic [ADDRESS_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]    rom_data_in,
  output logic                     rom_rd_en,
  output logic [ADDRESS_WIDTH-1:0] rom_address,
  output logic [DATA_WIDTH-1:0]    data_captured,
  output logic                     data_valid,
  output logic                     busy
);

  localparam int unsigned PW = cnt_width(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam int unsigned WW = cnt_width(ROM_LATENCY);
  localparam logic [WW-1:0] WAIT_LAST = (ROM_LATENCY >= 2) ? WW'(ROM_LATENCY - 2) : '0;

  seq_state_t    state_q;
  seq_state_t    state_d;
  logic [PW-1:0] presc_q;
  logic [WW-1:0] wait_q;
  logic          pending_q;
  logic          btn_press;
  logic          scan_tick;
  logic          step_req;
  logic          do_load;
  logic          do_capture;
  logic          take_req;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_step_btn (
    .clk  (clk),
    .rst  (rst),
    .btn_n(btn_step_n),
    .press(btn_press)
  );

  // Prescaler parks at zero whenever auto-scan is off so each enable starts a full period.
  always_ff @(posedge clk) begin
    if (rst || !mode_auto) begin
      presc_q <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign scan_tick = mode_auto && (presc_q == PRESC_LAST);
  assign step_req  = btn_press | scan_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rom_rd_en  = 1'b0;
    busy       = 1'b1;
    do_load    = 1'b0;
    do_capture = 1'b0;
    take_req   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        // A load in the same cycle as a request wins and the request is lost.
        if (load_en) begin
          do_load = 1'b1;
        end else if (step_req || pending_q) begin
          take_req = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rom_rd_en = 1'b1;
        state_d   = (ROM_LATENCY <= 1) ? ST_CAPTURE : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        do_capture = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_address   <= '0;
      data_captured <= '0;
      data_valid    <= 1'b0;
      pending_q     <= 1'b0;
      wait_q        <= '0;
    end else begin
      data_valid <= do_capture;
      if (do_load) begin
        rom_address <= load_addr;
      end else if (do_capture) begin
        rom_address <= rom_address + 1'b1;
      end
      if (do_capture) begin
        data_captured <= rom_data_in;
      end
      if (take_req) begin
        pending_q <= 1'b0;
      end else if (busy && step_req) begin
        pending_q <= 1'b1;
      end
      if (state_q == ST_WAIT) begin
        wait_q <= wait_q + 1'b1;
      end else begin
        wait_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rom_addr_sequencer.sv
// Bench for rom_addr_sequencer: a latency-1 instance with the 4-cycle debouncer and a latency-3
// instance with a 1-cycle debouncer, both against a ROM holding addr*3 and a transaction scoreboard.
module tb_rom_addr_sequencer;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int SDIV = 10;
  localparam int LAT3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          btn_n = 1'b1;
  logic          mode_auto = 1'b0;
  logic          load_en = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [DW-1:0] rom_data;
  logic          rom_rd_en;
  logic [AW-1:0] rom_address;
  logic [DW-1:0] data_captured;
  logic          data_valid;
  logic          busy;

  logic          rst3 = 1'b1;
  logic          btn3_n = 1'b1;
  logic [DW-1:0] rom_data3;
  logic          rom_rd_en3;
  logic [AW-1:0] rom_address3;
  logic [DW-1:0] data_captured3;
  logic          data_valid3;
  logic          busy3;

  rom_addr_sequencer #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(1),
    .DEBOUNCE_CYCLES(4), .SCAN_DIV(SDIV)
  ) dut (
    .clk(clk), .rst(rst), .btn_step_n(btn_n), .mode_auto(mode_auto),
    .load_en(load_en), .load_addr(load_addr), .rom_data_in(rom_data),
    .rom_rd_en(rom_rd_en), .rom_address(rom_address), .data_captured(data_captured),
    .data_valid(data_valid), .busy(busy)
  );

  rom_addr_sequencer #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .ROM_LATENCY(LAT3),
    .DEBOUNCE_CYCLES(1), .SCAN_DIV(SDIV)
  ) dut3 (
    .clk(clk), .rst(rst3), .btn_step_n(btn3_n), .mode_auto(1'b0),
    .load_en(1'b0), .load_addr(8'h00), .rom_data_in(rom_data3),
    .rom_rd_en(rom_rd_en3), .rom_address(rom_address3), .data_captured(data_captured3),
    .data_valid(data_valid3), .busy(busy3)
  );

  function automatic logic [DW-1:0] rom_word(input int a);
    return DW'(a * 3);
  endfunction

  // ROM models: output is the addressed word only exactly LATENCY cycles after the read enable.
  logic          rom1_v = 1'b0;
  logic [AW-1:0] rom1_a = '0;
  always @(posedge clk) begin
    rom1_v <= rom_rd_en;
    rom1_a <= rom_address;
  end
  assign rom_data = rom1_v ? rom_word(int'(rom1_a)) : 16'hDEAD;

  logic [LAT3-1:0] rom3_v = '0;
  logic [AW-1:0]   rom3_a [LAT3];
  always @(posedge clk) begin
    rom3_v    <= {rom3_v[LAT3-2:0], rom_rd_en3};
    rom3_a[0] <= rom_address3;
    for (int s = 1; s < LAT3; s++) rom3_a[s] <= rom3_a[s-1];
  end
  assign rom_data3 = rom3_v[LAT3-1] ? rom_word(int'(rom3_a[LAT3-1])) : 16'hDEAD;

  int            cyc = 0;
  logic [AW-1:0] rd_q[$];
  logic [DW-1:0] dv_q[$];
  int            dv_t[$];
  logic [AW-1:0] rd3_q[$];
  int            rd3_t[$];
  logic [DW-1:0] dv3_q[$];
  int            dv3_t[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rom_rd_en) rd_q.push_back(rom_address);
    if (data_valid) begin
      dv_q.push_back(data_captured);
      dv_t.push_back(cyc);
    end
    if (rom_rd_en3) begin
      rd3_q.push_back(rom_address3);
      rd3_t.push_back(cyc);
    end
    if (data_valid3) begin
      dv3_q.push_back(data_captured3);
      dv3_t.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  int model_addr = 0;
  int model3_addr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_main();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset_outputs", {5'd0, rom_address, rom_rd_en, data_captured, data_valid, busy}, 32'd0);
    end
    rst = 1'b0;
    model_addr = 0;
    rd_q.delete(); dv_q.delete(); dv_t.delete();
  endtask

  task automatic press_btn();
    btn_n = 1'b0;
    cycles(8);
    btn_n = 1'b1;
    cycles(14);
  endtask

  // Every captured word must be the next address of the model, which then steps modulo 2**AW.
  task automatic drain(input string tag);
    int n = dv_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, 32'(dv_q[i]), 32'(rom_word(model_addr)));
      if (i < rd_q.size()) chk({tag, "_rd_addr"}, 32'(rd_q[i]), 32'(model_addr));
      model_addr = (model_addr + 1) % (1 << AW);
    end
    chk({tag, "_addr"}, 32'(rom_address), 32'(model_addr));
    rd_q.delete(); dv_q.delete(); dv_t.delete();
  endtask

  task automatic drain3(input string tag);
    int n = dv3_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, 32'(dv3_q[i]), 32'(rom_word(model3_addr)));
      if (i < rd3_q.size()) chk({tag, "_rd_addr"}, 32'(rd3_q[i]), 32'(model3_addr));
      model3_addr = (model3_addr + 1) % (1 << AW);
    end
    chk({tag, "_addr"}, 32'(rom_address3), 32'(model3_addr));
    rd3_q.delete(); rd3_t.delete(); dv3_q.delete(); dv3_t.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c0;
    int  n;
    int  ones;
    bit  seen;

    // Reset: all outputs low every reset cycle.
    reset_main();
    chk("reset3_outputs", {5'd0, rom_address3, rom_rd_en3, data_captured3, data_valid3, busy3}, 32'd0);

    // Short glitch is filtered; a held press gives one read at address 0.
    cycles(8);
    btn_n = 1'b0;
    cycles(2);
    btn_n = 1'b1;
    cycles(15);
    chk("bounce_no_read", rd_q.size(), 0);
    btn_n = 1'b0;
    cycles(6);
    btn_n = 1'b1;
    cycles(20);
    chk("held_press_reads", rd_q.size(), 1);
    chk("held_press_valids", dv_q.size(), 1);
    drain("held_press");

    // Load near the top, then two presses wrap the address.
    load_addr = 8'hFE;
    load_en = 1'b1;
    cycles(1);
    load_en = 1'b0;
    model_addr = 'hFE;
    cycles(2);
    chk("load_addr", rom_address, 32'hFE);
    press_btn();
    press_btn();
    chk("wrap_valids", dv_q.size(), 2);
    drain("wrap");

    // Auto scan: three ticks in 35 cycles, SCAN_DIV apart, first valid at tick + latency.
    reset_main();
    c0 = cyc;
    mode_auto = 1'b1;
    cycles(35);
    mode_auto = 1'b0;
    cycles(25);
    chk("auto_valids", dv_q.size(), 3);
    if (dv_t.size() >= 3) begin
      chk("auto_first_time", dv_t[0] - c0, (SDIV - 1) + 1 + 2);
      chk("auto_spacing1", dv_t[1] - dv_t[0], SDIV);
      chk("auto_spacing2", dv_t[2] - dv_t[1], SDIV);
    end
    drain("auto");
    cycles(30);
    chk("auto_off_quiet", dv_q.size(), 0);

    // Press/tick alignment sweep: exactly one offset merges both into a single read.
    ones = 0;
    for (int j = 0; j < 8; j++) begin
      for (int r = 0; r < 45; r++) begin
        if (r == 0) mode_auto = 1'b1;
        if (r == j) btn_n = 1'b0;
        if (r == 10) mode_auto = 1'b0;
        if (r == 16) btn_n = 1'b1;
        @(negedge clk);
      end
      n = dv_q.size();
      chk("sweep_reads_in_range", (n >= 1) && (n <= 2), 1);
      chk("sweep_rd_matches_valid", rd_q.size(), n);
      if (n == 1) ones++;
      drain("sweep");
    end
    chk("press_tick_merge_once", ones, 1);

    // Load held across a tick: load wins, no read.
    load_addr = 8'h40;
    for (int r = 0; r < 25; r++) begin
      if (r == 0) mode_auto = 1'b1;
      if (r == 8) load_en = 1'b1;
      if (r == 10) mode_auto = 1'b0;
      if (r == 11) load_en = 1'b0;
      @(negedge clk);
    end
    chk("load_beats_req_reads", rd_q.size(), 0);
    model_addr = 'h40;
    drain("load_beats_req");

    // Latency-3 instance: three presses two cycles apart -> one pending, one dropped.
    rst3 = 1'b0;
    model3_addr = 0;
    cycles(4);
    rd3_q.delete(); rd3_t.delete(); dv3_q.delete(); dv3_t.delete();
    for (int k = 0; k < 3; k++) begin
      btn3_n = 1'b0;
      cycles(1);
      btn3_n = 1'b1;
      cycles(1);
    end
    cycles(20);
    chk("pending_reads", rd3_q.size(), 2);
    chk("pending_valids", dv3_q.size(), 2);
    if (rd3_t.size() >= 1 && dv3_t.size() >= 1)
      chk("lat3_issue_to_valid", dv3_t[0] - rd3_t[0], LAT3 + 1);
    drain3("pending");

    // Reset while waiting on the ROM aborts the read.
    cycles(5);
    btn3_n = 1'b0;
    cycles(2);
    btn3_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (rom_rd_en3) seen = 1'b1;
    end
    chk("abort_issue_seen", seen, 1);
    @(negedge clk);
    chk("abort_busy_in_wait", busy3, 1);
    chk("abort_addr_held", rom_address3, model3_addr);
    rst3 = 1'b1;
    cycles(2);
    rst3 = 1'b0;
    chk("abort_addr_zero", rom_address3, 0);
    chk("abort_data_zero", data_captured3, 0);
    chk("abort_idle", {busy3, data_valid3}, 0);
    cycles(10);
    chk("abort_no_valid", dv3_q.size(), 0);
    rd3_q.delete(); rd3_t.delete();
    model3_addr = 0;
    btn3_n = 1'b0;
    cycles(2);
    btn3_n = 1'b1;
    cycles(15);
    chk("after_abort_reads", rd3_q.size(), 1);
    drain3("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
